// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage types and defaults: PC/instruction widths, bubble encoding and the
// {pc,inst} entry carried through the prefetch buffer.
package if_fetch_unit_pkg;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  localparam logic [PC_W-1:0]   DEF_RESET_PC = 32'h0000_0000;
  localparam int                DEF_PC_STEP  = 4;
  localparam logic [INST_W-1:0] DEF_NOP_INST = 32'hF000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port: valid/ready request channel plus an in-order,
// never back-pressured response channel.
interface if_fetch_unit_if;
  import if_fetch_unit_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [PC_W-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_unit_fetch_buffer.sv
// Small circular FIFO of {pc,inst} entries feeding IF/ID; clear wins over push.
module if_fetch_unit_fetch_buffer
  import if_fetch_unit_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             push,
  input  fetch_entry_t                     push_entry,
  input  logic                             pop,
  output fetch_entry_t                     head,
  output logic [$clog2(BUF_DEPTH):0]       count
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign push_ok = push && (count != CNT_W'(BUF_DEPTH));
  assign pop_ok  = pop && (count != '0);
  assign head    = fetch_entry_t'(mem[rd_ptr]);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage carries no reset: validity is tracked entirely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem[wr_ptr] <= push_entry;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, capped request issue, in-order response
// capture with redirect squashing, and NOP bubbles when the prefetch buffer is empty.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC  = DEF_RESET_PC,
  parameter int                PC_STEP   = DEF_PC_STEP,
  parameter int                BUF_DEPTH = 2,
  parameter logic [INST_W-1:0] NOP_INST  = DEF_NOP_INST
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [PC_W-1:0]      redirect_pc,
  if_fetch_unit_if.master      imem,
  output logic [INST_W-1:0]    IF_inst,
  output logic [PC_W-1:0]      IF_pc
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);

  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  rsp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] occ;
  logic [CNT_W:0]   committed;
  logic             room;
  logic             req_hs;
  logic             rsp_keep;
  logic             rsp_drop;
  logic             buf_pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  // Credit check uses registered counts only; a same-cycle pop does not free a slot.
  assign committed = {1'b0, occ} + {1'b0, outstanding};
  assign room      = committed < (CNT_W + 1)'(BUF_DEPTH);

  assign imem.imem_req_valid = reset && !redirect && room;
  assign imem.imem_req_addr  = fetch_pc;
  assign req_hs              = imem.imem_req_valid && imem.imem_req_ready;

  assign rsp_drop = imem.imem_rsp_valid && (discard != '0);
  assign rsp_keep = imem.imem_rsp_valid && (discard == '0);
  assign buf_pop  = !stall && (occ != '0);

  assign push_entry.pc   = rsp_pc;
  assign push_entry.inst = imem.imem_rsp_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_hs) - CNT_W'(imem.imem_rsp_valid);
      if (redirect) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        discard  <= outstanding - CNT_W'(imem.imem_rsp_valid);
      end else begin
        if (req_hs)   fetch_pc <= fetch_pc + STEP;
        if (rsp_keep) rsp_pc   <= rsp_pc + STEP;
        discard <= discard - CNT_W'(rsp_drop);
      end
    end
  end

  if_fetch_unit_fetch_buffer #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .clear      (redirect),
    .push       (rsp_keep),
    .push_entry (push_entry),
    .pop        (buf_pop),
    .head       (head),
    .count      (occ)
  );

  assign IF_inst = (occ == '0) ? NOP_INST : head.inst;
  assign IF_pc   = (occ == '0) ? '0       : head.pc;

  cap_invariant: assert property (@(posedge clk) disable iff (!reset)
    committed <= (CNT_W + 1)'(BUF_DEPTH));
endmodule
